// File: rtl/cam_frame_writer.sv
// Camera capture front end: samples OV7670 pins in the CLK domain, pairs bytes into
// pixels, converts each pixel to RGB332, optionally decimates by 2^DEC, and drives the
// write port of a frame RAM. Also reports completed frames and malformed lines.
module cam_frame_writer #(
  parameter int IMG_W  = 176,
  parameter int IMG_H  = 144,
  parameter int ADDR_W = 15,
  parameter int DEC    = 0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CAM_PCLK,
  input  logic              CAM_VSYNC,
  input  logic              CAM_HREF,
  input  logic [7:0]        CAM_DATA,
  input  logic [1:0]        MODE,
  input  logic              ENABLE,
  output logic              W_EN,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic [9:0]        X,
  output logic [9:0]        Y,
  output logic              FRAME_DONE,
  output logic [7:0]        FRAME_CNT,
  output logic              LINE_ERR
);

  // Source-domain counters are wider than X/Y so decimated sources still fit.
  localparam int            CW    = 12;
  localparam logic [CW-1:0] SRC_W = CW'(IMG_W << DEC);
  localparam logic [CW-1:0] DMASK = CW'((1 << DEC) - 1);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_ACTIVE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        rst_sync;
  logic              rst_n;
  logic              pclk_s1, pclk_s2, pclk_s3;
  logic              vs_s1, vs_s2, vs_s3;
  logic              hr_s1, hr_s2, hr_s3;
  logic [7:0]        dat_s1, dat_s2;
  logic [7:0]        hi_q;
  logic [1:0]        mode_q;
  logic              phase;
  logic [CW-1:0]     x_in, y_in;
  logic [CW-1:0]     xs_full, ys_full;
  logic [ADDR_W-1:0] row_base;
  logic              pclk_rise, vs_rise, vs_fall, hr_fall, byte_take;
  logic              row_kept, pix_kept, frame_start;

  // Pixel format conversion to RGB332.
  function automatic logic [7:0] to_rgb332(input logic [1:0] m, input logic [7:0] hi,
                                           input logic [7:0] lo, input logic [9:0] xs,
                                           input logic [9:0] ys);
    logic [9:0] sum;
    sum = xs + ys;
    case (m)
      2'd0:    return {hi[7:5], hi[2:0], lo[4:3]};
      2'd1:    return {hi[3:1], lo[7:5], lo[3:2]};
      2'd2:    return {hi[7:5], hi[7:5], hi[7:6]};
      default: return sum[7:0];
    endcase
  endfunction

  // Reset asserts asynchronously and releases in step with CLK.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Two-flop synchronisers for the camera control pins plus a third stage for edges.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      {pclk_s1, pclk_s2, pclk_s3} <= 3'b000;
      {vs_s1, vs_s2, vs_s3}       <= 3'b000;
      {hr_s1, hr_s2, hr_s3}       <= 3'b000;
    end else begin
      {pclk_s1, pclk_s2, pclk_s3} <= {CAM_PCLK, pclk_s1, pclk_s2};
      {vs_s1, vs_s2, vs_s3}       <= {CAM_VSYNC, vs_s1, vs_s2};
      {hr_s1, hr_s2, hr_s3}       <= {CAM_HREF, hr_s1, hr_s2};
    end
  end

  // Data byte path and high-byte holding register; no reset needed on pure data.
  always_ff @(posedge CLK) begin
    dat_s1 <= CAM_DATA;
    dat_s2 <= dat_s1;
    if (state_q == S_ACTIVE && byte_take && !phase) hi_q <= dat_s2;
  end

  assign pclk_rise = pclk_s2 & ~pclk_s3;
  assign vs_rise   = vs_s2 & ~vs_s3;
  assign vs_fall   = ~vs_s2 & vs_s3;
  assign hr_fall   = ~hr_s2 & hr_s3;
  assign byte_take = pclk_rise & hr_s2;

  assign xs_full  = x_in >> DEC;
  assign ys_full  = y_in >> DEC;
  assign row_kept = ((y_in & DMASK) == '0) && (ys_full < CW'(IMG_H));
  assign pix_kept = row_kept && ((x_in & DMASK) == '0) && (xs_full < CW'(IMG_W));

  // FSM state register.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and frame-level strobes.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    FRAME_DONE  = 1'b0;
    case (state_q)
      S_IDLE:   if (ENABLE && vs_rise) state_d = S_SYNC;
      S_SYNC:   if (vs_fall) begin
                  state_d     = S_ACTIVE;
                  frame_start = 1'b1;
                end
      S_ACTIVE: if (vs_rise) state_d = S_DONE;
      S_DONE:   begin
                  FRAME_DONE = 1'b1;
                  state_d    = ENABLE ? S_SYNC : S_IDLE;
                end
      default:  state_d = S_IDLE;
    endcase
  end

  // Byte pairing, line accounting and RAM write generation.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      W_EN      <= 1'b0;
      W_ADDR    <= '0;
      W_DATA    <= '0;
      X         <= '0;
      Y         <= '0;
      FRAME_CNT <= '0;
      LINE_ERR  <= 1'b0;
      mode_q    <= '0;
      phase     <= 1'b0;
      x_in      <= '0;
      y_in      <= '0;
      row_base  <= '0;
    end else begin
      W_EN <= 1'b0;
      if (state_q == S_DONE) FRAME_CNT <= FRAME_CNT + 8'd1;
      if (hr_fall) phase <= 1'b0;
      if (frame_start) begin
        mode_q   <= MODE;
        x_in     <= '0;
        y_in     <= '0;
        row_base <= '0;
        phase    <= 1'b0;
        LINE_ERR <= 1'b0;
      end else if (state_q == S_ACTIVE && !vs_rise) begin
        if (hr_fall) begin
          // A dangling odd byte or a wrong pixel count marks the frame as damaged.
          if (phase || x_in != SRC_W) LINE_ERR <= 1'b1;
          x_in <= '0;
          if (y_in != '1) y_in <= y_in + CW'(1);
          if (row_kept) row_base <= row_base + ADDR_W'(IMG_W);
        end else if (byte_take) begin
          phase <= ~phase;
          if (phase) begin
            if (x_in != '1) x_in <= x_in + CW'(1);
            if (pix_kept) begin
              W_EN   <= 1'b1;
              W_ADDR <= row_base + ADDR_W'(xs_full);
              X      <= xs_full[9:0];
              Y      <= ys_full[9:0];
              W_DATA <= to_rgb332(mode_q, hi_q, dat_s2, xs_full[9:0], ys_full[9:0]);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Bench for cam_frame_writer: two instances (plain and 2x decimated) share one camera
// stream; expected writes come from a coordinate-level model of the capture rules.
module tb_cam_frame_writer;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       CAM_PCLK, CAM_VSYNC, CAM_HREF;
  logic [7:0] CAM_DATA;
  logic [1:0] MODE;
  logic       ENABLE;

  logic       w_en0, fd0, le0;
  logic [5:0] w_addr0;
  logic [7:0] w_data0, fc0;
  logic [9:0] x0, y0;
  logic       w_en1, fd1, le1;
  logic [3:0] w_addr1;
  logic [7:0] w_data1, fc1;
  logic [9:0] x1, y1;

  int n_cmp = 0;
  int n_bad = 0;
  int done0 = 0;
  int done1 = 0;
  longint exp0[$];
  longint exp1[$];
  int line_len[8];
  bit line_odd[8];
  int nlines;
  int cnt_exp;
  int done_exp;
  bit lerr_exp;

  cam_frame_writer #(.IMG_W(8), .IMG_H(5), .ADDR_W(6), .DEC(0)) dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .CAM_PCLK(CAM_PCLK), .CAM_VSYNC(CAM_VSYNC),
    .CAM_HREF(CAM_HREF), .CAM_DATA(CAM_DATA), .MODE(MODE), .ENABLE(ENABLE),
    .W_EN(w_en0), .W_ADDR(w_addr0), .W_DATA(w_data0), .X(x0), .Y(y0),
    .FRAME_DONE(fd0), .FRAME_CNT(fc0), .LINE_ERR(le0));

  cam_frame_writer #(.IMG_W(4), .IMG_H(3), .ADDR_W(4), .DEC(1)) dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .CAM_PCLK(CAM_PCLK), .CAM_VSYNC(CAM_VSYNC),
    .CAM_HREF(CAM_HREF), .CAM_DATA(CAM_DATA), .MODE(MODE), .ENABLE(ENABLE),
    .W_EN(w_en1), .W_ADDR(w_addr1), .W_DATA(w_data1), .X(x1), .Y(y1),
    .FRAME_DONE(fd1), .FRAME_CNT(fc1), .LINE_ERR(le1));

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input longint obs, input longint expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint mkkey(input int addr, input int xs, input int ys, input int d);
    return (longint'(addr) << 28) | (longint'(xs) << 18) | (longint'(ys) << 8) | longint'(d);
  endfunction

  // Reference pixel conversion expressed as field arithmetic.
  function automatic int conv(input int m, input int hi, input int lo, input int xs, input int ys);
    case (m)
      0:       return (hi / 32) * 32 + (hi % 8) * 4 + (lo / 8) % 4;
      1:       return ((hi / 2) % 8) * 32 + (lo / 32) * 4 + (lo / 4) % 4;
      2:       return (hi / 32) * 36 + hi / 64;
      default: return (xs + ys) % 256;
    endcase
  endfunction

  // Expected write (if any) for source pixel (p, l) in the given instance.
  task automatic model_pix(input int dut, input int l, input int p, input int m,
                           input int hi, input int lo);
    int w, h, step, xs, ys;
    w    = (dut == 0) ? 8 : 4;
    h    = (dut == 0) ? 5 : 3;
    step = (dut == 0) ? 1 : 2;
    if (p % step == 0 && l % step == 0) begin
      xs = p / step;
      ys = l / step;
      if (xs < w && ys < h) begin
        if (dut == 0) exp0.push_back(mkkey(ys * w + xs, xs, ys, conv(m, hi, lo, xs, ys)));
        else          exp1.push_back(mkkey(ys * w + xs, xs, ys, conv(m, hi, lo, xs, ys)));
      end
    end
  endtask

  // Write monitor and frame-done counter, sampled on the falling edge.
  always @(negedge CLK) begin
    if (w_en0) begin
      check("dut0 write_expected", longint'(exp0.size() > 0), 1);
      if (exp0.size() > 0) check("dut0 write", mkkey(w_addr0, x0, y0, w_data0), exp0.pop_front());
    end
    if (w_en1) begin
      check("dut1 write_expected", longint'(exp1.size() > 0), 1);
      if (exp1.size() > 0) check("dut1 write", mkkey(w_addr1, x1, y1, w_data1), exp1.pop_front());
    end
    if (fd0) done0++;
    if (fd1) done1++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic cam_byte(input int b);
    CAM_DATA = 8'(b);
    tick(4);
    CAM_PCLK = 1'b1;
    tick(4);
    CAM_PCLK = 1'b0;
  endtask

  task automatic send_line(input int l, input int len, input bit odd, input int m, input bit expw);
    int hi, lo;
    CAM_HREF = 1'b1;
    tick(2);
    for (int p = 0; p < len; p++) begin
      hi = int'($urandom_range(0, 255));
      lo = int'($urandom_range(0, 255));
      if (expw) begin
        model_pix(0, l, p, m, hi, lo);
        model_pix(1, l, p, m, hi, lo);
      end
      cam_byte(hi);
      cam_byte(lo);
    end
    if (odd) cam_byte(int'($urandom_range(0, 255)));
    CAM_HREF = 1'b0;
    tick(16);
  endtask

  task automatic set_lines_ok();
    nlines = 6;
    for (int i = 0; i < 8; i++) begin
      line_len[i] = 8;
      line_odd[i] = 1'b0;
    end
  endtask

  // One VSYNC-low frame followed by the closing VSYNC rise.
  task automatic run_frame(input int fmode, input bit expw, input int flip_line,
                           input int flip_val, input int dis_line);
    MODE = 2'(fmode);
    tick(4);
    CAM_VSYNC = 1'b0;
    tick(20);
    for (int l = 0; l < nlines; l++) begin
      if (l == flip_line) MODE = 2'(flip_val);
      if (l == dis_line) ENABLE = 1'b0;
      send_line(l, line_len[l], line_odd[l], fmode, expw);
    end
    if (expw) begin
      lerr_exp = 1'b0;
      for (int l = 0; l < nlines; l++)
        if (line_odd[l] || line_len[l] != 8) lerr_exp = 1'b1;
      cnt_exp  = (cnt_exp + 1) % 256;
      done_exp = done_exp + 1;
    end
    CAM_VSYNC = 1'b1;
    tick(30);
  endtask

  task automatic frame_checks(input string tag);
    check({tag, " dut0 pending"}, exp0.size(), 0);
    check({tag, " dut1 pending"}, exp1.size(), 0);
    check({tag, " dut0 frame_cnt"}, fc0, cnt_exp);
    check({tag, " dut1 frame_cnt"}, fc1, cnt_exp);
    check({tag, " dut0 done_pulses"}, done0, done_exp);
    check({tag, " dut1 done_pulses"}, done1, done_exp);
    check({tag, " dut0 line_err"}, le0, lerr_exp);
    check({tag, " dut1 line_err"}, le1, lerr_exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " dut0 outputs"}, longint'({w_en0, w_addr0, w_data0, x0, y0, fd0, fc0, le0}), 0);
    check({tag, " dut1 outputs"}, longint'({w_en1, w_addr1, w_data1, x1, y1, fd1, fc1, le1}), 0);
  endtask

  initial begin
    RESET_N = 1'b0; CAM_PCLK = 1'b0; CAM_VSYNC = 1'b0; CAM_HREF = 1'b0;
    CAM_DATA = 8'h00; MODE = 2'd0; ENABLE = 1'b0;
    cnt_exp = 0; done_exp = 0; lerr_exp = 1'b0;
    set_lines_ok();
    tick(3);
    check_zero("in_reset");
    RESET_N = 1'b1;
    tick(5);
    check_zero("after_reset");

    // Arm and open the first frame.
    ENABLE = 1'b1;
    CAM_VSYNC = 1'b1;
    tick(20);

    run_frame(0, 1'b1, -1, 0, -1);
    frame_checks("f1_rgb565");

    line_len[2] = 7; line_odd[2] = 1'b1;
    line_len[3] = 9;
    run_frame(1, 1'b1, -1, 0, -1);
    frame_checks("f2_rgb444_bad_lines");

    set_lines_ok();
    run_frame(2, 1'b1, 2, 3, -1);
    frame_checks("f3_gray_mode_flip");

    run_frame(3, 1'b1, -1, 0, -1);
    frame_checks("f4_pattern");

    run_frame(0, 1'b1, -1, 0, 3);
    frame_checks("f5_disable_mid");

    run_frame(1, 1'b0, -1, 0, -1);
    frame_checks("f6_not_armed");

    // Re-arm, capture two lines, then reset in the middle of the frame.
    ENABLE = 1'b1;
    MODE = 2'd0;
    CAM_VSYNC = 1'b0;
    tick(20);
    CAM_VSYNC = 1'b1;
    tick(20);
    CAM_VSYNC = 1'b0;
    tick(20);
    send_line(0, 8, 1'b0, 0, 1'b1);
    send_line(1, 8, 1'b0, 0, 1'b1);
    tick(20);
    RESET_N = 1'b0;
    #1;
    check_zero("mid_frame_reset");
    tick(3);
    RESET_N = 1'b1;
    tick(5);
    cnt_exp = 0; done_exp = 0; done0 = 0; done1 = 0; lerr_exp = 1'b0;
    for (int l = 2; l < 6; l++) send_line(l, 8, 1'b0, 0, 1'b0);
    frame_checks("after_reset_no_capture");

    CAM_VSYNC = 1'b1;
    tick(20);
    run_frame(0, 1'b1, -1, 0, -1);
    frame_checks("f7_resumed");

    // Empty frames drive the frame counter through its wrap.
    for (int i = 0; i < 255; i++) begin
      CAM_VSYNC = 1'b0;
      tick(10);
      CAM_VSYNC = 1'b1;
      tick(10);
    end
    cnt_exp  = (cnt_exp + 255) % 256;
    done_exp = done_exp + 255;
    tick(10);
    frame_checks("frame_cnt_wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
